// File: rtl/hbm_pkg.sv
// Shared types and AXI constants for the HBM write port.
package hbm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_AW,
    WRITE,
    WAIT_B,
    DONE
  } hbm_state_e;

  localparam logic [2:0] AXI_SIZE_32B      = 3'b101;
  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

endpackage

// File: rtl/hbm_wr_port_if.sv
// AXI4 bundle between the HBM write port (master) and one HBM pseudo-channel (slave).
interface hbm_wr_port_if #(
  parameter int unsigned ID_WIDTH   = 20,
  parameter int unsigned ADDR_WIDTH = 34,
  parameter int unsigned DATA_WIDTH = 256
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/hbm_skid_buf.sv
// Two-entry registered valid/ready buffer; in_ready_o comes straight from the fill count,
// so neither in_valid_i nor out_ready_i reaches it combinationally.
module hbm_skid_buf #(
  parameter int unsigned DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            cnt_q, cnt_d;
  logic                  push, pop;

  // Handshakes and fill-count update
  always_comb begin
    in_ready_o  = (cnt_q != 2'd2);
    out_valid_o = (cnt_q != 2'd0);
    out_data_o  = mem_q[rd_ptr_q];
    push        = in_valid_i && in_ready_o;
    pop         = out_valid_o && out_ready_i;
    cnt_d       = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 2'd1;
    else if (!push && pop) cnt_d = cnt_q - 2'd1;
  end

  // Pointers and count
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: an entry is only read once the count says it was written
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end
endmodule

// File: rtl/hbm_wr_port.sv
// AXI4 write master streaming a contiguous region into one HBM pseudo-channel, one burst
// outstanding at a time. Optional HBM_WR_ERR_CHECK_EN adds a sticky bad-response flag.
module hbm_wr_port
  import hbm_pkg::*;
#(
  parameter int unsigned BURST_LEN  = 256,
  parameter int unsigned ID_WIDTH   = 20,
  parameter int unsigned ADDR_WIDTH = 34,
  parameter int unsigned DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  output logic                  done,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_err,
  hbm_wr_port_if.master         m_axi
);
  localparam int unsigned CntW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH:0] BurstBytes = (ADDR_WIDTH + 1)'(BURST_LEN * DATA_WIDTH / 8);

  hbm_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] curr_addr_q, curr_addr_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                  awvalid_q, awvalid_d;
  logic [CntW-1:0]       beat_cnt_q, beat_cnt_d;

  logic                  in_window, wvalid, wlast, bready;
  logic                  skid_in_ready, skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  aw_hs, w_hs, beat_last, addr_done;
  logic [ADDR_WIDTH:0]   next_addr;

  hbm_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .nrst        (nrst),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid && in_window),
    .in_ready_o  (skid_in_ready),
    .out_data_o  (skid_data),
    .out_valid_o (skid_valid),
    .out_ready_i (wvalid && m_axi.wready)
  );

  assign aw_hs     = awvalid_q && m_axi.awready;
  assign w_hs      = wvalid && m_axi.wready;
  assign beat_last = (beat_cnt_q == LastBeat);
  // One extra bit so an address wrap still counts as covering end_addr
  assign next_addr = {1'b0, curr_addr_q} + BurstBytes;
  assign addr_done = (next_addr >= {1'b0, end_addr});

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SEND_AW;
      SEND_AW: if (aw_hs) state_d = WRITE;
      WRITE:   if (w_hs && beat_last) state_d = WAIT_B;
      WAIT_B:  if (m_axi.bvalid) state_d = addr_done ? DONE : SEND_AW;
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    done      = (state_q == DONE);
    bready    = (state_q == WAIT_B);
    in_window = (state_q == SEND_AW) || (state_q == WRITE) || (state_q == WAIT_B);
    wvalid    = (state_q == WRITE) && skid_valid;
    wlast     = (state_q == WRITE) && beat_last;
  end

  // Datapath next-state: address, AW request and beat counter
  always_comb begin
    curr_addr_d = curr_addr_q;
    awaddr_d    = awaddr_q;
    awvalid_d   = awvalid_q;
    beat_cnt_d  = beat_cnt_q;
    if (state_q == IDLE && start) begin
      curr_addr_d = start_addr;
      awaddr_d    = start_addr;
      awvalid_d   = 1'b1;
      beat_cnt_d  = '0;
    end
    if (aw_hs) awvalid_d = 1'b0;
    if (w_hs) beat_cnt_d = beat_last ? '0 : beat_cnt_q + CntW'(1);
    if (state_q == WAIT_B && m_axi.bvalid && !addr_done) begin
      curr_addr_d = next_addr[ADDR_WIDTH-1:0];
      awaddr_d    = next_addr[ADDR_WIDTH-1:0];
      awvalid_d   = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      curr_addr_q <= '0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      curr_addr_q <= curr_addr_d;
      awaddr_q    <= awaddr_d;
      awvalid_q   <= awvalid_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

`ifdef HBM_WR_ERR_CHECK_EN
  logic wr_err_q, wr_err_d;

  // Sticky error: cleared by an accepted start, set by any non-OKAY response
  always_comb begin
    wr_err_d = wr_err_q;
    if (state_q == IDLE && start) wr_err_d = 1'b0;
    else if (m_axi.bvalid && bready && m_axi.bresp != AXI_RESP_OKAY) wr_err_d = 1'b1;
  end

  // Error flag register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) wr_err_q <= 1'b0;
    else       wr_err_q <= wr_err_d;
  end

  assign wr_err = wr_err_q;
  logic unused_b;
  assign unused_b = ^m_axi.bid;
`else
  assign wr_err = 1'b0;
  logic unused_b;
  assign unused_b = ^{m_axi.bid, m_axi.bresp};
`endif

  logic unused_r;
  assign unused_r = ^{m_axi.arready, m_axi.rid, m_axi.rdata, m_axi.rresp, m_axi.rlast,
                      m_axi.rvalid};

  assign in_ready = skid_in_ready && in_window;

  assign m_axi.awid    = '0;
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awlen   = 8'(BURST_LEN - 1);
  assign m_axi.awsize  = AXI_SIZE_32B;
  assign m_axi.awburst = AXI_BURST_INCR;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = AXI_CACHE_DEFAULT;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awqos   = 4'b0000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = skid_data;
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = wlast;
  assign m_axi.wvalid  = wvalid;
  assign m_axi.bready  = bready;

  assign m_axi.arid    = '0;
  assign m_axi.araddr  = '0;
  assign m_axi.arlen   = '0;
  assign m_axi.arsize  = '0;
  assign m_axi.arburst = '0;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = '0;
  assign m_axi.arprot  = '0;
  assign m_axi.arqos   = '0;
  assign m_axi.arvalid = 1'b0;
  assign m_axi.rready  = 1'b1;
endmodule

// File: tb/tb_hbm_wr_port.sv
// Bench for hbm_wr_port: AXI slave + stream source model, checked against expected
// burst addresses and beat data derived from start/end addresses.
module tb_hbm_wr_port;
  localparam int unsigned BL = 4;
  localparam int unsigned IW = 20;
  localparam int unsigned AW = 34;
  localparam int unsigned DW = 256;
  localparam longint      BB = 128;
`ifdef HBM_WR_ERR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          nrst, start, done, in_valid, in_ready, wr_err;
  logic [AW-1:0] start_addr, end_addr;
  logic [DW-1:0] in_data;

  hbm_wr_port_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  hbm_wr_port #(
    .BURST_LEN (BL), .ID_WIDTH (IW), .ADDR_WIDTH (AW), .DATA_WIDTH (DW)
  ) dut (
    .clk (clk), .nrst (nrst), .start (start), .done (done),
    .start_addr (start_addr), .end_addr (end_addr),
    .in_data (in_data), .in_valid (in_valid), .in_ready (in_ready),
    .wr_err (wr_err), .m_axi (axi)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state
  logic [DW-1:0] src_q[$], exp_q[$], w_q[$];
  logic [AW-1:0] exp_aw[$], aw_q[$];
  bit            wl_q[$];
  int  cyc, aw_cnt, b_cnt, wburst_cnt, b_pending;
  int  proto_err, const_err, stab_err, stall_obs, aw_stall, err_burst;
  int  done_cyc, last_b_cyc;
  bit  done_seen, rand_mode, prev_aw_wait;
  logic [AW-1:0] prev_awaddr;

  function automatic int n_bursts(input longint s, input longint e);
    if (e <= s) return 1;
    return int'((e - s + BB - 1) / BB);
  endfunction

  // Slave/source model: drive at negedge, observe the coming posedge's handshakes at +1
  task automatic bus_model();
    forever begin
      @(negedge clk);
      cyc++;
      if (!nrst) b_pending = 0;
      if (axi.awvalid && aw_stall > 0) begin
        axi.awready = 1'b0;
        aw_stall--;
      end else axi.awready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.wready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.bvalid = nrst && (b_pending > 0) && (rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1);
      axi.bresp  = (axi.bvalid && b_cnt == err_burst) ? 2'b10 : 2'b00;
      in_valid   = (src_q.size() > 0) && (rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1);
      in_data    = (src_q.size() > 0) ? src_q[0] : '0;
      #1;
      if (prev_aw_wait && (!axi.awvalid || axi.awaddr !== prev_awaddr)) stab_err++;
      prev_aw_wait = axi.awvalid && !axi.awready;
      prev_awaddr  = axi.awaddr;
      if (axi.awvalid && !axi.awready) stall_obs++;
      if (axi.wvalid && aw_cnt <= wburst_cnt) proto_err++;
      if (axi.awvalid && aw_cnt != b_cnt) proto_err++;
      if (axi.awvalid && axi.awready) begin
        aw_q.push_back(axi.awaddr);
        aw_cnt++;
        if (axi.awid != 0 || axi.awlen != 8'(BL - 1) || axi.awsize != 3'b101 ||
            axi.awburst != 2'b01 || axi.awlock != 1'b0 || axi.awcache != 4'b0011 ||
            axi.awprot != 3'b0 || axi.awqos != 4'b0) const_err++;
      end
      if (in_valid && in_ready) void'(src_q.pop_front());
      if (axi.wvalid && axi.wready) begin
        w_q.push_back(axi.wdata);
        wl_q.push_back(axi.wlast);
        if (axi.wstrb !== '1) const_err++;
        if (axi.wlast) begin
          b_pending++;
          wburst_cnt++;
        end
      end
      if (axi.bvalid && axi.bready) begin
        b_pending--;
        b_cnt++;
        last_b_cyc = cyc;
      end
      if (done && !done_seen) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
    end
  endtask

  task automatic launch(input logic [AW-1:0] s, input logic [AW-1:0] e);
    logic [DW-1:0] d;
    int nb;
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    nb = n_bursts(longint'(s), longint'(e));
    src_q.delete(); exp_q.delete(); w_q.delete(); wl_q.delete(); aw_q.delete(); exp_aw.delete();
    aw_cnt = 0; b_cnt = 0; wburst_cnt = 0; b_pending = 0; proto_err = 0; const_err = 0;
    stab_err = 0; stall_obs = 0; done_seen = 1'b0; prev_aw_wait = 1'b0;
    for (int k = 0; k < nb; k++) exp_aw.push_back(AW'(longint'(s) + k * BB));
    for (int i = 0; i < nb * int'(BL); i++) begin
      for (int w = 0; w < int'(DW) / 32; w++) d[w*32 +: 32] = $urandom();
      exp_q.push_back(d);
      src_q.push_back(d);
    end
    start_addr = s;
    end_addr   = e;
    start      = 1'b1;
  endtask

  task automatic wait_done(output bit to);
    to = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #2;
      if (done_seen) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic stop_and_idle();
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    total++;
    if ({done, in_ready, wr_err, axi.awvalid, axi.wvalid, axi.wlast, axi.bready} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outs got=%b want=0000000",
               {done, in_ready, wr_err, axi.awvalid, axi.wvalid, axi.wlast, axi.bready});
    end
    total++;
    if (axi.awaddr !== '0) begin
      bad++;
      $display("FAIL reset_awaddr got=%h want=0", axi.awaddr);
    end
    total++;
    if ({axi.arvalid, axi.rready} !== 2'b01) begin
      bad++;
      $display("FAIL read_tieoff got=%b want=01", {axi.arvalid, axi.rready});
    end
    nrst = 1'b1;
  endtask

  task automatic test_basic();
    bit to;
    int mism;
    rand_mode = 1'b0;
    launch(34'h0, 34'h100);
    wait_done(to);
    total++;
    if (to) begin bad++; $display("FAIL basic_timeout got=no_done want=done"); end
    total++;
    if (aw_q.size() != 2 || aw_q[0] !== 34'h0 || aw_q[1] !== 34'h80) begin
      bad++;
      $display("FAIL basic_aw got=%p want=0,80", aw_q);
    end
    mism = 0;
    for (int i = 0; i < w_q.size() && i < exp_q.size(); i++)
      if (w_q[i] !== exp_q[i] || wl_q[i] !== (i % BL == BL - 1)) mism++;
    total++;
    if (w_q.size() != 8 || mism != 0) begin
      bad++;
      $display("FAIL basic_w got=%0d beats/%0d bad want=8/0", w_q.size(), mism);
    end
    total++;
    if (done_cyc - last_b_cyc != 1) begin
      bad++;
      $display("FAIL basic_done_lat got=%0d want=1", done_cyc - last_b_cyc);
    end
    total++;
    if (const_err != 0 || proto_err != 0) begin
      bad++;
      $display("FAIL basic_fields got=%0d/%0d want=0/0", const_err, proto_err);
    end
    stop_and_idle();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b want=0", done); end
  endtask

  task automatic test_aw_stall();
    bit to;
    rand_mode = 1'b0;
    launch(34'h0, 34'h80);
    aw_stall = 5;
    wait_done(to);
    total++;
    if (to) begin bad++; $display("FAIL stall_timeout got=no_done want=done"); end
    total++;
    if (stall_obs != 5 || stab_err != 0) begin
      bad++;
      $display("FAIL stall_aw got=%0d waits/%0d unstable want=5/0", stall_obs, stab_err);
    end
    total++;
    if (proto_err != 0 || aw_q.size() != 1 || aw_q[0] !== 34'h0 || w_q.size() != 4) begin
      bad++;
      $display("FAIL stall_order got=%0d/%0d/%0d want=0/1/4", proto_err, aw_q.size(), w_q.size());
    end
    stop_and_idle();
  endtask

  task automatic test_random_gaps();
    bit to;
    int mism;
    rand_mode = 1'b1;
    launch(34'h4000, 34'h4180);
    wait_done(to);
    rand_mode = 1'b0;
    total++;
    if (to) begin bad++; $display("FAIL rand_timeout got=no_done want=done"); end
    mism = 0;
    for (int i = 0; i < w_q.size() && i < exp_q.size(); i++)
      if (w_q[i] !== exp_q[i] || wl_q[i] !== (i % BL == BL - 1)) mism++;
    total++;
    if (w_q.size() != 12 || mism != 0) begin
      bad++;
      $display("FAIL rand_w got=%0d beats/%0d bad want=12/0", w_q.size(), mism);
    end
    mism = 0;
    for (int k = 0; k < aw_q.size() && k < exp_aw.size(); k++) if (aw_q[k] !== exp_aw[k]) mism++;
    total++;
    if (aw_q.size() != 3 || mism != 0 || proto_err != 0 || stab_err != 0) begin
      bad++;
      $display("FAIL rand_aw got=%0d/%0d/%0d/%0d want=3/0/0/0",
               aw_q.size(), mism, proto_err, stab_err);
    end
    stop_and_idle();
  endtask

  task automatic test_single_hold();
    bit to;
    launch(34'h1000, 34'h1001);
    wait_done(to);
    total++;
    if (to || aw_q.size() != 1 || aw_q[0] !== 34'h1000 || w_q.size() != 4) begin
      bad++;
      $display("FAIL single_burst got=%0d/%0d to=%0d want=1/4", aw_q.size(), w_q.size(), to);
    end
    repeat (10) @(negedge clk);
    #2;
    total++;
    if (done !== 1'b1 || aw_cnt != 1) begin
      bad++;
      $display("FAIL hold_done got=%b/%0d want=1/1", done, aw_cnt);
    end
    stop_and_idle();
    total++;
    if (done !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL hold_release got=%b%b want=00", done, in_ready);
    end
    launch(34'h2000, 34'h1000);
    wait_done(to);
    total++;
    if (to || aw_q.size() != 1 || aw_q[0] !== 34'h2000 || w_q.size() != 4) begin
      bad++;
      $display("FAIL end_below got=%0d/%0d to=%0d want=1/4", aw_q.size(), w_q.size(), to);
    end
    stop_and_idle();
  endtask

  task automatic test_err_resp();
    bit to;
    err_burst = 0;
    launch(34'h0, 34'h100);
    wait_done(to);
    err_burst = -1;
    total++;
    if (to || b_cnt != 2 || w_q.size() != 8) begin
      bad++;
      $display("FAIL err_complete got=%0d B/%0d W to=%0d want=2/8", b_cnt, w_q.size(), to);
    end
    total++;
    if (wr_err !== EXP_ERR) begin bad++; $display("FAIL err_set got=%b want=%b", wr_err, EXP_ERR); end
    stop_and_idle();
    total++;
    if (wr_err !== EXP_ERR) begin
      bad++;
      $display("FAIL err_sticky got=%b want=%b", wr_err, EXP_ERR);
    end
    launch(34'h0, 34'h80);
    wait_done(to);
    total++;
    if (to || wr_err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear got=%b to=%0d want=0", wr_err, to);
    end
    stop_and_idle();
  endtask

  task automatic test_reset_mid();
    bit to;
    int mism;
    launch(34'h0, 34'h100);
    to = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #2;
      if (w_q.size() >= 2) begin
        to = 1'b0;
        break;
      end
    end
    total++;
    if (to) begin bad++; $display("FAIL mid_reach got=%0d beats want=2", w_q.size()); end
    nrst = 1'b0;
    #1;
    total++;
    if ({done, in_ready, wr_err, axi.awvalid, axi.wvalid, axi.wlast, axi.bready} !== 7'b0 ||
        axi.awaddr !== '0) begin
      bad++;
      $display("FAIL mid_reset got=%b/%h want=0000000/0",
               {done, in_ready, wr_err, axi.awvalid, axi.wvalid, axi.wlast, axi.bready},
               axi.awaddr);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    nrst = 1'b1;
    launch(34'h800, 34'h900);
    wait_done(to);
    mism = 0;
    for (int i = 0; i < w_q.size() && i < exp_q.size(); i++) if (w_q[i] !== exp_q[i]) mism++;
    total++;
    if (to || w_q.size() != 8 || mism != 0 || aw_q.size() != 2 || aw_q[0] !== 34'h800) begin
      bad++;
      $display("FAIL mid_restart got=%0d beats/%0d bad/%0d aw to=%0d want=8/0/2",
               w_q.size(), mism, aw_q.size(), to);
    end
    stop_and_idle();
  endtask

  initial begin
    nrst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    start_addr = '0; end_addr = '0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.bid = '0; axi.arready = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = 2'b00;
    axi.rlast = 1'b0; axi.rvalid = 1'b0;
    rand_mode = 1'b0; aw_stall = 0; err_burst = -1; cyc = 0;
    fork
      bus_model();
    join_none
    test_reset();
    test_basic();
    test_aw_stall();
    test_random_gaps();
    test_single_hold();
    test_err_resp();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule
